// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serialises IF fetches and MEM loads/stores onto one single-port synchronous SRAM
module unified_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  output logic              dm_misalign,
  output logic              pipe_stall,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  state_t state, state_nx;
  logic [1:0] cnt;
  logic own_dm, own_wr;
  logic [2:0] own_f3;
  logic [1:0] own_lo;
  logic dm_pend, if_pend, misal, grant_dm, grant_if, rd_done, wr_done, adv;
  logic [3:0] we_nx;
  logic [31:0] wdata_nx, rd_shift, ld_ext;
  logic unused_bits;
  assign unused_bits = ^{if_addr[31:ADDR_W], if_addr[1:0], dm_addr[31:ADDR_W]};
  assign dm_pend = (dm_read | dm_write) & ~dm_done;
  assign if_pend = if_req & ~if_done;
  assign pipe_stall = ~rst & (if_pend | dm_pend);
  assign adv = ~pipe_stall;
  assign misal = (dm_funct3[1:0] == 2'b01 && dm_addr[0]) || (dm_funct3 == 3'b010 && dm_addr[1:0] != 2'b00);
  assign grant_dm = state == IDLE && dm_pend;
  assign grant_if = state == IDLE && !dm_pend && if_pend;
  assign rd_done = state == WAIT && cnt == 2'd0;
  assign wr_done = state == ACCESS && own_wr;
  assign we_nx = dm_funct3[1:0] == 2'b00 ? 4'b0001 << dm_addr[1:0] :
                 dm_funct3[1:0] == 2'b01 ? (dm_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_nx = dm_funct3[1:0] == 2'b00 ? {4{dm_wdata[7:0]}} :
                    dm_funct3[1:0] == 2'b01 ? {2{dm_wdata[15:0]}} : dm_wdata;
  assign rd_shift = sram_rdata >> {own_lo, 3'b000};
  assign ld_ext = own_f3 == 3'b000 ? {{24{rd_shift[7]}}, rd_shift[7:0]} :
                  own_f3 == 3'b001 ? {{16{rd_shift[15]}}, rd_shift[15:0]} :
                  own_f3 == 3'b100 ? {24'b0, rd_shift[7:0]} :
                  own_f3 == 3'b101 ? {16'b0, rd_shift[15:0]} : sram_rdata;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: grant in IDLE (misaligned data stays in IDLE), one ACCESS cycle, then wait out the read latency
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = (grant_dm & ~misal) | grant_if ? ACCESS : IDLE;
    else if (state == ACCESS) state_nx = own_wr ? IDLE : WAIT;
    else state_nx = cnt == 2'd0 ? IDLE : WAIT;
  end
  // SRAM strobes, ownership, latency counter, result capture and done flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sram_en <= 1'b0;
      sram_we <= 4'b0;
      sram_addr <= '0;
      sram_wdata <= 32'b0;
      cnt <= 2'd0;
      own_dm <= 1'b0;
      own_wr <= 1'b0;
      own_f3 <= 3'b0;
      own_lo <= 2'b0;
      if_rdata <= 32'b0;
      if_done <= 1'b0;
      dm_rdata <= 32'b0;
      dm_done <= 1'b0;
      dm_misalign <= 1'b0;
    end else begin
      sram_en <= (grant_dm & ~misal) | grant_if;
      sram_we <= grant_dm && dm_write && !misal ? we_nx : 4'b0;
      if ((grant_dm & ~misal) | grant_if) begin
        sram_addr <= grant_dm ? dm_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
        sram_wdata <= grant_dm ? wdata_nx : 32'b0;
        own_dm <= grant_dm;
        own_wr <= grant_dm & dm_write;
        own_f3 <= dm_funct3;
        own_lo <= dm_addr[1:0];
      end
      cnt <= state == ACCESS ? 2'(LAT - 1) : state == WAIT ? cnt - 2'd1 : cnt;
      if_rdata <= rd_done && !own_dm ? sram_rdata : if_rdata;
      dm_rdata <= grant_dm && misal ? 32'b0 : rd_done && own_dm ? ld_ext : dm_rdata;
      if_done <= adv ? 1'b0 : rd_done && !own_dm ? 1'b1 : if_done;
      dm_done <= adv ? 1'b0 : (grant_dm && misal) || wr_done || (rd_done && own_dm) ? 1'b1 : dm_done;
      dm_misalign <= adv ? 1'b0 : grant_dm && misal ? 1'b1 : dm_misalign;
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scoreboard bench for the unified memory arbiter (LAT=1 and LAT=3 instances)
module tb_unified_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1, init = 1'b1;
  always #5 clk = ~clk;
  logic if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0;
  logic [31:0] if_addr = 32'b0, dm_addr = 32'b0, dm_wdata = 32'b0;
  logic [2:0] dm_funct3 = 3'b0;
  logic [31:0] if_rdata, dm_rdata, sram_wdata, sram_rdata, r1;
  logic if_done, dm_done, dm_misalign, pipe_stall, sram_en;
  logic [3:0] sram_we;
  logic [10:0] sram_addr;
  logic [31:0] mem [0:2047];
  logic if_req3 = 1'b0, dm_read3 = 1'b0;
  logic [31:0] if_addr3 = 32'b0, dm_addr3 = 32'b0;
  logic [2:0] dm_funct3_3 = 3'b0;
  logic [31:0] if_rdata3, dm_rdata3, sram_wdata3, sram_rdata3, q1, q2, q3;
  logic if_done3, dm_done3, dm_misalign3, pipe_stall3, sram_en3;
  logic [3:0] sram_we3;
  logic [10:0] sram_addr3;
  logic [31:0] mem3 [0:2047];
  int en3_cnt = 0, en3_dm = 0;
  int cmp = 0, bad = 0;
  logic [31:0] exp_q [$];
  unified_mem_arbiter #(.ADDR_W(13), .LAT(1)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_funct3(dm_funct3),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_misalign(dm_misalign), .pipe_stall(pipe_stall),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );
  unified_mem_arbiter #(.ADDR_W(13), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_done(if_done3),
    .dm_read(dm_read3), .dm_write(1'b0), .dm_addr(dm_addr3), .dm_wdata(32'b0), .dm_funct3(dm_funct3_3),
    .dm_rdata(dm_rdata3), .dm_done(dm_done3), .dm_misalign(dm_misalign3), .pipe_stall(pipe_stall3),
    .sram_en(sram_en3), .sram_we(sram_we3), .sram_addr(sram_addr3), .sram_wdata(sram_wdata3), .sram_rdata(sram_rdata3)
  );
  // single-port SRAM with byte lanes, 1-cycle read latency
  always @(posedge clk) begin
    if (init) begin
      mem[1] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'h80FF0000;
    end else if (sram_en)
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    r1 <= (sram_en && sram_we == 4'b0) ? mem[sram_addr] : r1;
  end
  assign sram_rdata = r1;
  // read-only SRAM with 3-cycle read latency, plus strobe counters
  always @(posedge clk) begin
    if (init) begin
      mem3[0] <= 32'hCAFEF00D;
      mem3[9] <= 32'h11223344;
    end
    q1 <= (sram_en3 && sram_we3 == 4'b0) ? mem3[sram_addr3] : q1;
    q2 <= q1;
    q3 <= q2;
    if (sram_en3) begin
      en3_cnt <= en3_cnt + 1;
      if (sram_addr3 == 11'd9) en3_dm <= en3_dm + 1;
    end
  end
  assign sram_rdata3 = q3;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      cmp++;
      bad++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
    end else chk(tag, obs, exp_q.pop_front());
  endtask
  task automatic dm_set(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    dm_read = rd;
    dm_write = wr;
    dm_addr = a;
    dm_wdata = wd;
    dm_funct3 = f3;
  endtask
  initial begin
    step(2);
    chk("rst_en", 32'(sram_en), 1'b0);
    chk("rst_we", 32'(sram_we), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_flags", {if_done, dm_done, dm_misalign, pipe_stall}, 0);
    rst = 1'b0;
    init = 1'b0;
    step(1);
    if_addr = 32'h10;
    if_req = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    step(1);
    chk("f_en_c1", 32'(sram_en), 1);
    chk("f_addr_c1", 32'(sram_addr), 4);
    chk("f_stall_c1", 32'(pipe_stall), 1);
    step(1);
    chk("f_done_c2", 32'(if_done), 0);
    step(1);
    chk("f_done_c3", 32'(if_done), 1);
    chk("f_stall_c3", 32'(pipe_stall), 0);
    pop_chk("f_rdata", if_rdata);
    if_req = 1'b0;
    step(1);
    chk("f_clear", 32'(if_done), 0);
    dm_set(1'b1, 1'b0, 32'h23, 32'h0, 3'b000);
    if_req = 1'b1;
    exp_q.push_back(32'hFFFFFF80);
    exp_q.push_back(32'hDEADBEEF);
    step(1);
    chk("lf_en_c1", 32'(sram_en), 1);
    chk("lf_addr_c1", 32'(sram_addr), 8);
    step(2);
    chk("lf_dmdone_c3", 32'(dm_done), 1);
    chk("lf_stall_c3", 32'(pipe_stall), 1);
    chk("lf_ifdone_c3", 32'(if_done), 0);
    pop_chk("lf_lb", dm_rdata);
    step(1);
    chk("lf_en_c4", 32'(sram_en), 1);
    chk("lf_addr_c4", 32'(sram_addr), 4);
    step(1);
    chk("lf_stall_c5", 32'(pipe_stall), 1);
    step(1);
    chk("lf_ifdone_c6", 32'(if_done), 1);
    chk("lf_stall_c6", 32'(pipe_stall), 0);
    pop_chk("lf_fetch", if_rdata);
    dm_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    if_req = 1'b0;
    step(1);
    chk("lf_clear", {if_done, dm_done}, 0);
    dm_set(1'b0, 1'b1, 32'h06, 32'h1234ABCD, 3'b001);
    step(1);
    chk("sh_en", 32'(sram_en), 1);
    chk("sh_we", 32'(sram_we), 32'hC);
    chk("sh_wdata", sram_wdata, 32'hABCDABCD);
    chk("sh_addr", 32'(sram_addr), 1);
    step(1);
    chk("sh_done_c2", 32'(dm_done), 1);
    chk("sh_we_c2", 32'(sram_we), 0);
    dm_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(1);
    dm_set(1'b1, 1'b0, 32'h06, 32'h0, 3'b101);
    exp_q.push_back(32'h0000ABCD);
    step(3);
    chk("lhu_done", 32'(dm_done), 1);
    pop_chk("lhu_data", dm_rdata);
    dm_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(1);
    dm_set(1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    step(2);
    rst = 1'b1;
    #1;
    chk("ar_en", 32'(sram_en), 0);
    chk("ar_addr", 32'(sram_addr), 0);
    chk("ar_dm_rdata", dm_rdata, 0);
    chk("ar_if_rdata", if_rdata, 0);
    chk("ar_flags", {if_done, dm_done, dm_misalign, pipe_stall}, 0);
    step(1);
    rst = 1'b0;
    exp_q.push_back(32'h80FF0000);
    step(1);
    chk("ar_re_en", 32'(sram_en), 1);
    chk("ar_re_addr", 32'(sram_addr), 8);
    step(1);
    chk("ar_re_c2", 32'(dm_done), 0);
    step(1);
    chk("ar_re_done", 32'(dm_done), 1);
    pop_chk("ar_re_lw", dm_rdata);
    dm_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(1);
    dm_set(1'b1, 1'b0, 32'h05, 32'h0, 3'b010);
    step(1);
    chk("mis_en", 32'(sram_en), 0);
    chk("mis_flags", {dm_done, dm_misalign}, 2'b11);
    chk("mis_rdata", dm_rdata, 0);
    chk("mis_stall", 32'(pipe_stall), 0);
    dm_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(1);
    chk("mis_clear", {dm_done, dm_misalign}, 0);
    dm_read3 = 1'b1;
    dm_addr3 = 32'h24;
    dm_funct3_3 = 3'b010;
    if_req3 = 1'b1;
    if_addr3 = 32'h0;
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'hCAFEF00D);
    step(1);
    chk("l3_en_c1", 32'(sram_en3), 1);
    step(3);
    chk("l3_done_c4", 32'(dm_done3), 0);
    step(1);
    chk("l3_done_c5", 32'(dm_done3), 1);
    chk("l3_stall_c5", 32'(pipe_stall3), 1);
    pop_chk("l3_lw", dm_rdata3);
    step(1);
    chk("l3_fen_c6", 32'(sram_en3), 1);
    chk("l3_faddr_c6", 32'(sram_addr3), 0);
    step(3);
    chk("l3_ifdone_c9", 32'(if_done3), 0);
    step(1);
    chk("l3_ifdone_c10", 32'(if_done3), 1);
    chk("l3_stall_c10", 32'(pipe_stall3), 0);
    chk("l3_dmheld_c10", 32'(dm_done3), 1);
    pop_chk("l3_fetch", if_rdata3);
    dm_read3 = 1'b0;
    if_req3 = 1'b0;
    step(2);
    chk("l3_dm_pulses", 32'(en3_dm), 1);
    chk("l3_all_pulses", 32'(en3_cnt), 2);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
